// File: rtl/diff_scan_ctrl_pkg.sv
// rtl/diff_scan_ctrl_pkg.sv - shared widths and state encoding for the difference scanner
// Contents:
//   DEF_WIDTH / DEF_IDXW : default operand width and index width (log2 of width)
//   state_t              : controller state encoding
package diff_scan_ctrl_pkg;

    localparam int DEF_WIDTH = 32;
    localparam int DEF_IDXW  = 5;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/diff_scan_ctrl_if.sv
// rtl/diff_scan_ctrl_if.sv - control, operand and index-handshake bundle of the difference scanner
// Signals:
//   start, a, b             : scan request and operands (driven by master)
//   idx_ready               : consumer accepts idx (driven by master)
//   busy, idx_valid, idx    : scan status and index stream (driven by slave)
//   done, eq, count, first_idx : completion pulse and scan summary (driven by slave)
interface diff_scan_ctrl_if
    import diff_scan_ctrl_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int IDXW  = DEF_IDXW
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             idx_valid;
    logic [IDXW-1:0]  idx;
    logic             idx_ready;
    logic             done;
    logic             eq;
    logic [IDXW:0]    count;
    logic [IDXW-1:0]  first_idx;

    modport master (
        output start, a, b, idx_ready,
        input  busy, idx_valid, idx, done, eq, count, first_idx
    );

    modport slave (
        input  start, a, b, idx_ready,
        output busy, idx_valid, idx, done, eq, count, first_idx
    );
endinterface

// File: rtl/diff_scan_ctrl_lsb_encoder.sv
// rtl/diff_scan_ctrl_lsb_encoder.sv - binary index of the lowest set bit of a vector
// Ports:
//   x   in  WIDTH : vector to search
//   idx out IDXW  : position of the lowest set bit of x, 0 when x is 0
module lsb_encoder #(
    parameter int WIDTH = 32,
    parameter int IDXW  = 5
) (
    input  logic [WIDTH-1:0] x,
    output logic [IDXW-1:0]  idx
);
    logic [WIDTH-1:0] iso;

    // Two's-complement trick leaves only the lowest set bit (one-hot or zero).
    assign iso = x & ~(x - WIDTH'(1));

    // One-hot to binary: OR together the positions of the (single) set bit.
    always_comb begin
        idx = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (iso[i]) begin
                idx = idx | IDXW'(i);
            end
        end
    end
endmodule

// File: rtl/diff_scan_ctrl.sv
// rtl/diff_scan_ctrl.sv - sequenced scan of all bit positions where two operands differ
// Ports:
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : slave side of diff_scan_ctrl_if (start/a/b in, index stream and summary out)
module diff_scan_ctrl
    import diff_scan_ctrl_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int IDXW  = DEF_IDXW
) (
    input  logic             clk,
    input  logic             rst_n,
    diff_scan_ctrl_if.slave  bus
);
    state_t           state;
    logic [WIDTH-1:0] mask;
    logic [WIDTH-1:0] mask_next;
    logic [IDXW-1:0]  low_idx;
    logic [IDXW:0]    count_q;
    logic [IDXW-1:0]  first_idx_q;
    logic             eq_q;

    lsb_encoder #(
        .WIDTH (WIDTH),
        .IDXW  (IDXW)
    ) u_lsb_encoder (
        .x   (mask),
        .idx (low_idx)
    );

    // Mask with the index currently on offer removed.
    assign mask_next = mask & (mask - WIDTH'(1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            mask        <= '0;
            count_q     <= '0;
            first_idx_q <= '0;
            eq_q        <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        mask        <= bus.a ^ bus.b;
                        eq_q        <= (bus.a == bus.b);
                        count_q     <= '0;
                        first_idx_q <= '0;
                        state       <= (bus.a == bus.b) ? DONE : SCAN;
                    end
                end
                SCAN: begin
                    if (bus.idx_ready) begin
                        mask    <= mask_next;
                        count_q <= count_q + (IDXW+1)'(1);
                        if (count_q == '0) begin
                            first_idx_q <= low_idx;
                        end
                        if (mask_next == '0) begin
                            state <= DONE;
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Status outputs decode the state register directly, so they carry no
    // combinational path from any input.
    assign bus.busy      = (state != IDLE);
    assign bus.idx_valid = (state == SCAN);
    assign bus.done      = (state == DONE);
    assign bus.idx       = (state == SCAN) ? low_idx : '0;
    assign bus.count     = count_q;
    assign bus.first_idx = first_idx_q;
    assign bus.eq        = eq_q;
endmodule

// File: tb/tb_diff_scan_ctrl.sv
// tb/tb_diff_scan_ctrl.sv - self-checking bench for diff_scan_ctrl
module tb_diff_scan_ctrl;
    import diff_scan_ctrl_pkg::*;

    logic clk;
    logic rst_n;
    int   checks;
    int   fails;

    diff_scan_ctrl_if s ();

    diff_scan_ctrl dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (s.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [63:0] rdy;
        bit          inj;
        int          exp_done;
        int          exp_count;
        int          exp_first;
        bit          exp_eq;
    } vec_t;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference: the scan is an ordered list of differing positions, drained
    // one entry per accepted handshake, followed by a single done cycle.
    task automatic run_scan(input logic [31:0] va, input logic [31:0] vb,
                            input logic [63:0] rdy_pat, input bit rnd, input bit inject,
                            output int done_cyc, output int oc, output int of, output int oe);
        int q[$];
        int cnt;
        int first;
        bit eqm;
        bit fin;
        logic r;
        for (int i = 0; i < 32; i++) if (va[i] != vb[i]) q.push_back(i);
        eqm = (va == vb);
        cnt = 0; first = 0; fin = 0;
        done_cyc = -1; oc = 0; of = 0; oe = 0;
        s.start = 1'b1; s.a = va; s.b = vb; s.idx_ready = 1'b0;
        step();
        s.start = 1'b0; s.a = $urandom; s.b = $urandom;
        for (int cyc = 1; cyc <= 400 && !fin; cyc++) begin
            if (inject && cyc == 2) begin
                s.start = 1'b1; s.a = 32'hF; s.b = 32'h0;
            end else begin
                s.start = 1'b0;
            end
            r = rnd ? 1'($urandom_range(0, 1)) : rdy_pat[(cyc > 64) ? 63 : cyc - 1];
            s.idx_ready = r;
            chk("busy", s.busy, 1);
            chk("count_running", s.count, cnt);
            if (q.size() > 0) begin
                chk("idx_valid", s.idx_valid, 1);
                chk("idx", s.idx, q[0]);
                chk("done_early", s.done, 0);
                if (r) begin
                    if (cnt == 0) first = q[0];
                    cnt++;
                    void'(q.pop_front());
                end
            end else begin
                chk("idx_valid_done", s.idx_valid, 0);
                chk("idx_done", s.idx, 0);
                chk("done", s.done, 1);
                chk("first_idx", s.first_idx, first);
                chk("eq", s.eq, eqm);
                done_cyc = cyc; oc = s.count; of = s.first_idx; oe = s.eq;
                fin = 1;
            end
            step();
        end
        if (!fin) begin
            checks++; fails++;
            $display("FAIL scan_timeout a=%h b=%h", va, vb);
        end
        s.start = 1'b0; s.idx_ready = 1'b0;
        chk("idle_busy", s.busy, 0);
        chk("idle_done", s.done, 0);
        chk("idle_valid", s.idx_valid, 0);
        chk("hold_count", s.count, cnt);
        chk("hold_first", s.first_idx, first);
        chk("hold_eq", s.eq, eqm);
    endtask

    vec_t vecs[6];

    initial begin
        int dc, oc, of, oe;
        logic [31:0] ra, rb;
        checks = 0; fails = 0;
        vecs[0] = '{32'h0000_0005, 32'h0, ~64'h0, 0, 3, 2, 0, 0};
        vecs[1] = '{32'hDEAD_BEEF, 32'hDEAD_BEEF, ~64'h0, 0, 1, 0, 0, 1};
        vecs[2] = '{32'hFFFF_FFFF, 32'h0, ~64'h0, 0, 33, 32, 0, 0};
        vecs[3] = '{32'h8000_0010, 32'h0, ~64'h7, 0, 6, 2, 4, 0};
        vecs[4] = '{32'h0000_00F0, 32'h0, ~64'h0, 1, 5, 4, 4, 0};
        vecs[5] = '{32'hC000_0000, 32'h4000_0000, ~64'h0, 0, 2, 1, 31, 0};

        rst_n = 1'b0;
        s.start = 1'b0; s.a = '0; s.b = '0; s.idx_ready = 1'b0;
        step(); step();
        chk("rst_busy", s.busy, 0);
        chk("rst_valid", s.idx_valid, 0);
        chk("rst_done", s.done, 0);
        chk("rst_idx", s.idx, 0);
        chk("rst_count", s.count, 0);
        chk("rst_first", s.first_idx, 0);
        chk("rst_eq", s.eq, 0);
        rst_n = 1'b1;
        step();

        foreach (vecs[k]) begin
            run_scan(vecs[k].a, vecs[k].b, vecs[k].rdy, 0, vecs[k].inj, dc, oc, of, oe);
            chk($sformatf("vec%0d_done_cycle", k), dc, vecs[k].exp_done);
            chk($sformatf("vec%0d_count", k), oc, vecs[k].exp_count);
            chk($sformatf("vec%0d_first", k), of, vecs[k].exp_first);
            chk($sformatf("vec%0d_eq", k), oe, vecs[k].exp_eq);
        end

        // Asynchronous reset in the middle of a 4-bit scan.
        s.start = 1'b1; s.a = 32'h0000_000F; s.b = 32'h0; s.idx_ready = 1'b1;
        step();
        s.start = 1'b0;
        step();
        chk("mid_valid_before_rst", s.idx_valid, 1);
        rst_n = 1'b0;
        #1;
        chk("arst_busy", s.busy, 0);
        chk("arst_valid", s.idx_valid, 0);
        chk("arst_idx", s.idx, 0);
        chk("arst_done", s.done, 0);
        chk("arst_count", s.count, 0);
        chk("arst_first", s.first_idx, 0);
        chk("arst_eq", s.eq, 0);
        #2;
        rst_n = 1'b1;
        s.idx_ready = 1'b0;
        step();
        chk("post_rst_idle", s.busy, 0);
        run_scan(32'h0000_0030, 32'h0, ~64'h0, 0, 0, dc, oc, of, oe);
        chk("post_rst_done_cycle", dc, 3);
        chk("post_rst_count", oc, 2);
        chk("post_rst_first", of, 4);

        // Randomised operands and consumer back-pressure against the list model.
        for (int n = 0; n < 40; n++) begin
            ra = $urandom;
            case (n % 4)
                0: rb = ra;
                1: rb = ra ^ (32'h1 << $urandom_range(0, 31));
                2: rb = ra ^ ($urandom & $urandom & $urandom);
                default: rb = $urandom;
            endcase
            run_scan(ra, rb, ~64'h0, 1, n[0], dc, oc, of, oe);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end
endmodule

// File: doc/diff_scan_ctrl.md
# diff_scan_ctrl

Multi-cycle controller that enumerates, lowest first, every bit position where two 32-bit operands differ. It extends the single-shot least-significant-difference operation of the miniRISC ALU into a sequenced scan. Each index is delivered over a valid/ready handshake, and a running count of differing bits is kept. It sits beside the ALU and is started by the control unit for multi-bit difference operations; results are drained by the writeback/consumer stage.

## Interface
- WIDTH, 32, operand width (power of two)
- IDXW, 5, index width, log2(WIDTH)

- clk  in  1  rising-edge clock
- rst_n  in  1  reset, asynchronous, active-low
- start  in  1  request a scan; sampled only in IDLE
- a  in  WIDTH  operand A, sampled with start
- b  in  WIDTH  operand B, sampled with start
- busy  out  1  high in SCAN and DONE
- idx_valid  out  1  idx holds a valid differing-bit index
- idx  out  IDXW  current lowest differing bit of remaining mask
- idx_ready  in  1  consumer accepts idx this cycle
- done  out  1  one-cycle pulse, scan finished
- eq  out  1  registered (a == b) of last accepted start
- count  out  IDXW+1  indices transferred in current/last scan
- first_idx  out  IDXW  first index transferred in current/last scan; 0 if eq

## Operation
- Registered state: mask[WIDTH-1:0], state, count, first_idx, eq.
- IDLE, start=1:
  - mask <= a ^ b, eq <= (a == b), count <= 0, first_idx <= 0.
  - Next state is DONE if a == b, else SCAN.
- SCAN:
  - idx_valid = 1.
  - idx = position of lowest set bit of mask (combinational from register).
  - On idx_valid & idx_ready:
    - mask <= mask & (mask - 1); count <= count + 1.
    - If count == 0, first_idx <= idx.
    - If the cleared mask == 0, go to DONE.
- DONE: done = 1 for exactly one cycle, then IDLE.
- start while busy is ignored and produces no effect and no queueing.
- idx = 0 whenever mask == 0 or state != SCAN.
- idx and idx_valid must stay stable while idx_ready is low.
- count saturates naturally at WIDTH (max 32 fits in IDXW+1 bits); no wrap.
- Async reset (any state, including mid-scan):
  - state = IDLE, mask = 0, count = 0, first_idx = 0, eq = 0.
  - busy, idx_valid, done all 0; idx = 0.
  - Any in-flight scan is discarded.

## Timing
- Start accepted at edge 0; idx_valid high from cycle 1.
- With idx_ready tied high and N differing bits:
  - one index per cycle, cycles 1..N;
  - done in cycle N+1;
  - IDLE in cycle N+2, where the next start is accepted.
- Equal operands: done in cycle 1; idx_valid never asserted.
- Each cycle idx_ready is low adds one stall cycle; no index is lost or duplicated.
- count, first_idx and eq are valid from done and held until the next accepted start.

## Structure
- Shared package/header holds:
  - WIDTH/IDXW defaults;
  - state encoding IDLE=2'd0, SCAN=2'd1, DONE=2'd2.
- One sub-module, lsb_encoder (WIDTH, IDXW):
  - isolates the lowest set bit as x & ~(x - 1), then one-hot-to-binary encodes it;
  - outputs 0 for x == 0.
- Controller FSM, mask/count registers and handshake logic stay in diff_scan_ctrl.

## Test plan
- a=32'h0000_0005, b=0, idx_ready=1:
  - idx=0 in cycle 1, idx=2 in cycle 2;
  - done in cycle 3; count=2, first_idx=0, eq=0.
- a=b=32'hDEAD_BEEF:
  - eq=1, done in cycle 1, no idx_valid;
  - count=0, first_idx=0.
- a=32'hFFFF_FFFF, b=0, idx_ready=1:
  - idx 0..31 in cycles 1..32;
  - done in cycle 33; count=6'd32.
- a=32'h8000_0010, b=0, idx_ready low for cycles 1–3, then high:
  - idx=4 held stable for cycles 1–4, idx=31 in cycle 5;
  - done in cycle 6; count=2, first_idx=4.
- Start pulsed with a=32'hF, b=0 during SCAN of an earlier request: ignored; the earlier scan completes unchanged.
- rst_n dropped in cycle 2 of a 4-bit scan:
  - all outputs 0 immediately (asynchronous);
  - a start after release begins a fresh scan with count=0.
